// File: rtl/switch_op_decoder_if.sv
// Operator bus between the switch decoder and the calculator core.
// Carries the display mirror, the operator index and its valid/ack handshake.
interface switch_op_decoder_if #(
    parameter int NUM_SW = 8,
    parameter int IDX_W  = 4
);
    logic              i_ack;
    logic [NUM_SW-1:0] o_led;
    logic [7:0]        reg_lcd;
    logic [IDX_W-1:0]  o_op_idx;
    logic              o_op_valid;
    logic              o_err;

    // Decoder side: drives the operator and display, receives the ack
    modport master (
        input  i_ack,
        output o_led, reg_lcd, o_op_idx, o_op_valid, o_err
    );

    // Core side: consumes the operator and returns the ack
    modport slave (
        output i_ack,
        input  o_led, reg_lcd, o_op_idx, o_op_valid, o_err
    );
endinterface

// File: rtl/switch_op_decoder.sv
// DIP-switch operator selector: synchronises and debounces the switch bank,
// classifies the accepted pattern and presents the selected operator to the
// core through a valid/ack handshake, with LED and LCD glyph mirrors.
module switch_op_decoder #(
    parameter int NUM_SW     = 8,
    parameter int DEB_CYCLES = 16,
    parameter int STICKY     = 0,
    parameter int IDX_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SW-1:0]    i_sw_dip,
    switch_op_decoder_if.master  bus
);

    typedef enum logic [1:0] {IDLE, PEND, HELD, ERR} state_t;

    localparam logic [15:0] DEB_MAX  = 16'(DEB_CYCLES);
    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);
    localparam logic [7:0]  LCD_BLANK = 8'h20;
    localparam logic [7:0]  LCD_ERR   = 8'h3F;

    logic [NUM_SW-1:0] sync1_q, sync2_q;
    logic [NUM_SW-1:0] cand_q, cand_d;
    logic [NUM_SW-1:0] stable_q, stable_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [4:0]        ones;
    logic [IDX_W-1:0]  hot_idx;

    state_t            state_q, state_d;
    logic [NUM_SW-1:0] led_q, led_d;
    logic [7:0]        lcd_q, lcd_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    // LCD character for operator index k; indices past the symbol set show digits
    function automatic logic [7:0] glyph(input logic [IDX_W-1:0] k);
        logic [7:0] kk;
        kk = 8'(k);
        case (kk)
            8'd0:    glyph = 8'h2B;
            8'd1:    glyph = 8'h2D;
            8'd2:    glyph = 8'hD7;
            8'd3:    glyph = 8'h2F;
            8'd4:    glyph = 8'hF7;
            8'd5:    glyph = 8'h5E;
            8'd6:    glyph = 8'h21;
            8'd7:    glyph = 8'h3D;
            default: glyph = 8'h30 + (kk - 8'd8);
        endcase
    endfunction

    // Debounce: a candidate must hold for DEB_CYCLES cycles before it becomes stable
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else begin
            if (cnt_q != DEB_MAX) cnt_d = cnt_q + 16'd1;
            if (cnt_q == DEB_LAST) stable_d = cand_q;
        end
    end

    // Synchroniser and debounce state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= i_sw_dip;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Count set bits of the stable pattern and locate the operator index of the set bit
    always_comb begin
        ones    = '0;
        hot_idx = '0;
        for (int b = 0; b < NUM_SW; b++) begin
            if (stable_q[b]) begin
                ones    = ones + 5'd1;
                hot_idx = IDX_W'(NUM_SW - 1 - b);
            end
        end
    end

    // Operator FSM next state and next registered outputs
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        lcd_d   = lcd_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (ones >= 5'd2) begin
            state_d = ERR;
            err_d   = 1'b1;
            valid_d = 1'b0;
            led_d   = '0;
            lcd_d   = LCD_ERR;
        end else if (ones == 5'd1) begin
            if (hot_idx != idx_q || !(state_q == PEND || state_q == HELD)) begin
                state_d = PEND;
                valid_d = 1'b1;
                err_d   = 1'b0;
                idx_d   = hot_idx;
                led_d   = stable_q;
                lcd_d   = glyph(hot_idx);
            end else if (state_q == PEND && bus.i_ack) begin
                state_d = HELD;
                valid_d = 1'b0;
            end
        end else begin
            if (STICKY == 0 || state_q == ERR) begin
                state_d = IDLE;
                led_d   = '0;
                lcd_d   = LCD_BLANK;
                idx_d   = '0;
                valid_d = 1'b0;
                err_d   = 1'b0;
            end else if (state_q == PEND && bus.i_ack) begin
                state_d = HELD;
                valid_d = 1'b0;
            end
        end
    end

    // Operator FSM state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            led_q   <= '0;
            lcd_q   <= LCD_BLANK;
            idx_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            lcd_q   <= lcd_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_led      = led_q;
    assign bus.reg_lcd    = lcd_q;
    assign bus.o_op_idx   = idx_q;
    assign bus.o_op_valid = valid_q;
    assign bus.o_err      = err_q;

endmodule

// File: tb/tb_switch_op_decoder.sv
// Directed bench for switch_op_decoder: three instances cover the default
// non-sticky 8-switch build, the sticky build and a 12-switch build.
module tb_switch_op_decoder;

    logic        clk;
    logic        rst;
    logic [7:0]  sw_a;
    logic [7:0]  sw_b;
    logic [11:0] sw_c;

    int checks;
    int failures;

    switch_op_decoder_if #(.NUM_SW(8),  .IDX_W(4)) if_a ();
    switch_op_decoder_if #(.NUM_SW(8),  .IDX_W(4)) if_b ();
    switch_op_decoder_if #(.NUM_SW(12), .IDX_W(4)) if_c ();

    switch_op_decoder #(.NUM_SW(8), .DEB_CYCLES(4), .STICKY(0), .IDX_W(4)) dut_a (
        .clk(clk), .rst(rst), .i_sw_dip(sw_a), .bus(if_a.master)
    );
    switch_op_decoder #(.NUM_SW(8), .DEB_CYCLES(4), .STICKY(1), .IDX_W(4)) dut_b (
        .clk(clk), .rst(rst), .i_sw_dip(sw_b), .bus(if_b.master)
    );
    switch_op_decoder #(.NUM_SW(12), .DEB_CYCLES(4), .STICKY(0), .IDX_W(4)) dut_c (
        .clk(clk), .rst(rst), .i_sw_dip(sw_c), .bus(if_c.master)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle just after the last one
    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        sw_a       = '0;
        sw_b       = '0;
        sw_c       = '0;
        if_a.i_ack = 1'b0;
        if_b.i_ack = 1'b0;
        if_c.i_ack = 1'b0;

        // Reset values
        waitEdges(2);
        checkOutput("rst_led",   32'(if_a.o_led),      32'h00);
        checkOutput("rst_lcd",   32'(if_a.reg_lcd),    32'h20);
        checkOutput("rst_idx",   32'(if_a.o_op_idx),   32'h0);
        checkOutput("rst_valid", 32'(if_a.o_op_valid), 32'h0);
        checkOutput("rst_err",   32'(if_a.o_err),      32'h0);

        // Latency: switch 7 (k=0) appears at edge 8, not before
        rst  = 1'b1;
        sw_a = 8'h80;
        waitEdges(7);
        checkOutput("lat7_valid", 32'(if_a.o_op_valid), 32'h0);
        checkOutput("lat7_lcd",   32'(if_a.reg_lcd),    32'h20);
        waitEdges(1);
        checkOutput("lat8_led",   32'(if_a.o_led),      32'h80);
        checkOutput("lat8_lcd",   32'(if_a.reg_lcd),    32'h2B);
        checkOutput("lat8_idx",   32'(if_a.o_op_idx),   32'h0);
        checkOutput("lat8_valid", 32'(if_a.o_op_valid), 32'h1);

        // Glitch of 3 cycles is rejected
        sw_a = 8'h04;
        waitEdges(3);
        sw_a = 8'h80;
        waitEdges(10);
        checkOutput("glitch_lcd", 32'(if_a.reg_lcd),  32'h2B);
        checkOutput("glitch_idx", 32'(if_a.o_op_idx), 32'h0);

        // Held pattern is accepted: bit 2 is operator 5
        sw_a = 8'h04;
        waitEdges(10);
        checkOutput("hold_lcd",   32'(if_a.reg_lcd),    32'h5E);
        checkOutput("hold_idx",   32'(if_a.o_op_idx),   32'h5);
        checkOutput("hold_led",   32'(if_a.o_led),      32'h04);
        checkOutput("hold_valid", 32'(if_a.o_op_valid), 32'h1);

        // One-cycle ack drops valid, display retained
        if_a.i_ack = 1'b1;
        waitEdges(1);
        if_a.i_ack = 1'b0;
        checkOutput("ack_valid", 32'(if_a.o_op_valid), 32'h0);
        checkOutput("ack_lcd",   32'(if_a.reg_lcd),    32'h5E);
        waitEdges(3);
        checkOutput("held_valid", 32'(if_a.o_op_valid), 32'h0);

        // New operator k=7 raises valid again
        sw_a = 8'h01;
        waitEdges(8);
        checkOutput("k7_idx",   32'(if_a.o_op_idx),   32'h7);
        checkOutput("k7_lcd",   32'(if_a.reg_lcd),    32'h3D);
        checkOutput("k7_valid", 32'(if_a.o_op_valid), 32'h1);

        // Multi-hot pattern enters the error display
        sw_a = 8'h90;
        waitEdges(7);
        checkOutput("multi7_err", 32'(if_a.o_err), 32'h0);
        waitEdges(1);
        checkOutput("multi_err",   32'(if_a.o_err),      32'h1);
        checkOutput("multi_valid", 32'(if_a.o_op_valid), 32'h0);
        checkOutput("multi_led",   32'(if_a.o_led),      32'h00);
        checkOutput("multi_lcd",   32'(if_a.reg_lcd),    32'h3F);
        checkOutput("multi_idx",   32'(if_a.o_op_idx),   32'h7);

        // Leaving error with a one-hot pattern: bit 4 is operator 3
        sw_a = 8'h10;
        waitEdges(8);
        checkOutput("k3_err",   32'(if_a.o_err),      32'h0);
        checkOutput("k3_lcd",   32'(if_a.reg_lcd),    32'h2F);
        checkOutput("k3_valid", 32'(if_a.o_op_valid), 32'h1);
        checkOutput("k3_idx",   32'(if_a.o_op_idx),   32'h3);

        // Non-sticky release withdraws the pending operator
        sw_a = 8'h00;
        waitEdges(8);
        checkOutput("zero_led",   32'(if_a.o_led),      32'h00);
        checkOutput("zero_lcd",   32'(if_a.reg_lcd),    32'h20);
        checkOutput("zero_idx",   32'(if_a.o_op_idx),   32'h0);
        checkOutput("zero_valid", 32'(if_a.o_op_valid), 32'h0);

        // Sticky build: accept bit 5 (k=2), ack, then release
        sw_b = 8'h20;
        waitEdges(8);
        checkOutput("st_lcd",   32'(if_b.reg_lcd),    32'hD7);
        checkOutput("st_valid", 32'(if_b.o_op_valid), 32'h1);
        if_b.i_ack = 1'b1;
        waitEdges(1);
        if_b.i_ack = 1'b0;
        checkOutput("st_ack_valid", 32'(if_b.o_op_valid), 32'h0);
        sw_b = 8'h00;
        waitEdges(10);
        checkOutput("st_zero_led",   32'(if_b.o_led),      32'h20);
        checkOutput("st_zero_lcd",   32'(if_b.reg_lcd),    32'hD7);
        checkOutput("st_zero_idx",   32'(if_b.o_op_idx),   32'h2);
        checkOutput("st_zero_valid", 32'(if_b.o_op_valid), 32'h0);

        // Reselecting the held operator does not raise a new valid
        sw_b = 8'h20;
        waitEdges(10);
        checkOutput("st_resel_valid", 32'(if_b.o_op_valid), 32'h0);
        checkOutput("st_resel_lcd",   32'(if_b.reg_lcd),    32'hD7);

        // Sticky error is cleared by all switches off
        sw_b = 8'h30;
        waitEdges(10);
        checkOutput("st_err", 32'(if_b.o_err), 32'h1);
        sw_b = 8'h00;
        waitEdges(10);
        checkOutput("st_err_clr",     32'(if_b.o_err),   32'h0);
        checkOutput("st_err_clr_lcd", 32'(if_b.reg_lcd), 32'h20);
        checkOutput("st_err_clr_led", 32'(if_b.o_led),   32'h00);

        // 12-switch build: bit 3 is operator 8, shown as digit '0'
        sw_c = 12'h008;
        waitEdges(8);
        checkOutput("w12_led",   32'(if_c.o_led),      32'h008);
        checkOutput("w12_lcd",   32'(if_c.reg_lcd),    32'h30);
        checkOutput("w12_idx",   32'(if_c.o_op_idx),   32'h8);
        checkOutput("w12_valid", 32'(if_c.o_op_valid), 32'h1);

        // Asynchronous reset mid-handshake clears outputs immediately
        rst = 1'b0;
        #1;
        checkOutput("arst_led",   32'(if_c.o_led),      32'h000);
        checkOutput("arst_lcd",   32'(if_c.reg_lcd),    32'h20);
        checkOutput("arst_idx",   32'(if_c.o_op_idx),   32'h0);
        checkOutput("arst_valid", 32'(if_c.o_op_valid), 32'h0);

        // After release the pattern is debounced again from scratch
        waitEdges(1);
        rst = 1'b1;
        waitEdges(7);
        checkOutput("rdeb7_valid", 32'(if_c.o_op_valid), 32'h0);
        waitEdges(1);
        checkOutput("rdeb8_valid", 32'(if_c.o_op_valid), 32'h1);
        checkOutput("rdeb8_lcd",   32'(if_c.reg_lcd),    32'h30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/switch_op_decoder.md
Name: switch_op_decoder

Overview:
- Parametrised successor to the calculator's DIP-switch operator selector.
- Synchronises and debounces an N-bit switch bank, then classifies it as none, one-hot or multi-hot.
- Drives the operator LED mirror and the LCD operator glyph.
- Presents the selected operator index to the calculator core through a valid/ack handshake.
- Error and optional sticky-hold modes are new in this generation.

Parameters:
- NUM_SW, 8, number of switches (2..16); switch bit NUM_SW-1-k is operator index k.
- DEB_CYCLES, 16, consecutive stable cycles required before a switch pattern is accepted (1..65535).
- STICKY, 0, 0 = releasing all switches clears the selection; 1 = the last valid operator is held until a different one is selected.
- IDX_W, 4, width of o_op_idx; must be >= clog2(NUM_SW).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_sw_dip  in  NUM_SW  raw switch inputs, asynchronous to clk.
- i_ack  in  1  core accepts the current operator while o_op_valid=1.
- o_led  out  NUM_SW  one-hot mirror of the accepted operator.
- reg_lcd  out  8  LCD character code of the accepted operator.
- o_op_idx  out  IDX_W  accepted operator index k.
- o_op_valid  out  1  new operator pending for the core.
- o_err  out  1  accepted pattern is multi-hot.

Behaviour:
- Reset (rst=0, asynchronous) sets all internal registers to 0: sync flops, candidate, stable, debounce counter.
- Reset outputs: o_led=0, reg_lcd=8'h20 (blank), o_op_idx=0, o_op_valid=0, o_err=0, FSM=IDLE.
- Reset takes effect immediately, including mid-debounce or mid-handshake. After release the pattern must be re-debounced from zero.
- Synchroniser: 2-flop sync on i_sw_dip.
- Debounce, evaluated each edge:
  - if sync != cand: cand<=sync, cnt<=0;
  - else if cnt != DEB_CYCLES: cnt<=cnt+1;
  - when sync==cand and cnt==DEB_CYCLES-1: stable<=cand.
  - A glitch shorter than DEB_CYCLES cycles never reaches stable.
- Classify stable as ZERO (no bits), ONE (exactly one bit) or MULTI (two or more bits).
- FSM states are IDLE, PEND, HELD and ERR. It uses registered outputs updated one edge after stable changes.
- Total latency: a clean input change is visible on the outputs at the (DEB_CYCLES+4)th rising edge. Edge 1 is the first edge sampling the new value.
- ONE, from any state, when the index differs from the current o_op_idx or the state is not PEND/HELD:
  - go to PEND, o_op_valid=1, o_err=0;
  - o_op_idx=k, o_led=1<<(NUM_SW-1-k), reg_lcd=glyph(k).
- Re-accepting the same index while in HELD does not re-raise o_op_valid.
- PEND with i_ack=1 on an edge: go to HELD, o_op_valid=0 on the next cycle. Display and index are retained.
- PEND with a new one-hot index before ack: the latest index wins, o_op_valid stays 1 and the outputs update.
- PEND with i_ack=1 on the same edge as a stable change to a new index: the new index is loaded and o_op_valid stays 1. The old operator counts as acked.
- ZERO with STICKY=0: go to IDLE, all outputs return to reset values. A pending valid is withdrawn.
- ZERO with STICKY=1: the state and all outputs are unchanged.
- MULTI, from any state: go to ERR.
  - o_err=1, o_op_valid=0, o_led=0, reg_lcd=8'h3F ('?').
  - o_op_idx keeps its last value.
  - ERR is left only by a stable ONE (to PEND) or ZERO (to IDLE, even when STICKY=1).
- i_ack outside PEND is ignored.
- Glyph table:
  - k=0 '+' 8'h2B, k=1 '-' 8'h2D, k=2 8'hD7, k=3 '/' 8'h2F;
  - k=4 8'hF7, k=5 '^' 8'h5E, k=6 '!' 8'h21, k=7 '=' 8'h3D;
  - k>=8 shows '0'+(k-8) for k<=17. With NUM_SW<=16 this covers 8'h30..8'h37.
- The debounce counter is 16 bits and saturates at DEB_CYCLES; it never wraps.

Test Plan:
1. Reset and latency, DEB_CYCLES=4, STICKY=0: hold rst=0, then release; set i_sw_dip=8'h80 → outputs unchanged through edge 7; at edge 8: o_led=8'h80, reg_lcd=8'h2B, o_op_idx=0, o_op_valid=1.
2. Glitch reject: pulse i_sw_dip=8'h04 for 3 cycles with DEB_CYCLES=4 → no output change. Hold it for 10 cycles → reg_lcd=8'h5E, o_op_idx=5.
3. Handshake: in PEND assert i_ack for 1 cycle → o_op_valid=0 next cycle, reg_lcd held. Next change to 8'h01 with no ack → o_op_idx=7, reg_lcd=8'h3D, o_op_valid stays 1.
4. Multi-hot: stable 8'h90 → o_err=1, o_op_valid=0, o_led=0, reg_lcd=8'h3F. Then 8'h10 → o_err=0, reg_lcd=8'h2F, o_op_valid=1.
5. Sticky: STICKY=1, accept 8'h20, then ack, then switches to 8'h00 → o_led=8'h20, reg_lcd=8'hD7, o_op_valid=0 held. Reselect 8'h20 → no new valid. STICKY=0 repeat → outputs return to blank/0.
6. Width generalisation: NUM_SW=12, i_sw_dip=12'h008 (k=8) → o_led=12'h008, reg_lcd=8'h30. Assert rst=0 mid-PEND → all outputs at reset values immediately.
